// File: rtl/counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// counter_sweep_ctrl
//
// Sequencer for a bounded 8-bit up/down counter (range LO..HI). It accepts a
// sweep request (start value, end value, pass count) and loads the counter
// with the start value. It then ping-pongs the counter between the two
// endpoints for the requested number of passes. At the end it reports
// completion, and flags an error when there was one.
//
// Optional feature, selected by the macro CTRL_TIMEOUT_EN:
//   When the macro is defined, a per-pass watchdog aborts the sweep with an
//   error. It fires once the running cycles without a target hit exceed
//   |end-start| + TIMEOUT_SLACK. The TIMEOUT_SLACK parameter exists only in
//   that build. With the macro undefined there is no watchdog.
//
// Ports:
//   clk              in   rising-edge clock
//   reset_al_in      in   asynchronous active-low reset
//   start_in         in   sweep request, sampled in IDLE only
//   start_val_in     in   [7:0] first endpoint
//   end_val_in       in   [7:0] second endpoint
//   passes_in        in   [3:0] number of endpoint-to-endpoint traverses
//   hold_in          in   pause the sweep (counter frozen), RUN only
//   abort_in         in   terminate the sweep with an error, RUN only
//   busy_out         out  high in every state except IDLE
//   done_out         out  one-cycle completion pulse
//   err_out          out  one-cycle error pulse, coincident with done_out
//   pass_cnt_out     out  [3:0] passes completed in the current/last sweep
//   cnt_q_in         in   [7:0] counter current value
//   cnt_load_en_out  out  counter synchronous load enable
//   cnt_d_out        out  [7:0] counter load data
//   cnt_up_out       out  counter direction, 1 = up
// ---------------------------------------------------------------------------
module counter_sweep_ctrl #(
  parameter logic [7:0] LO = 8'd10,
  parameter logic [7:0] HI = 8'd40
`ifdef CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_SLACK = 4
`endif
) (
  input  logic       clk,
  input  logic       reset_al_in,
  input  logic       start_in,
  input  logic [7:0] start_val_in,
  input  logic [7:0] end_val_in,
  input  logic [3:0] passes_in,
  input  logic       hold_in,
  input  logic       abort_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out,
  output logic [3:0] pass_cnt_out,
  input  logic [7:0] cnt_q_in,
  output logic       cnt_load_en_out,
  output logic [7:0] cnt_d_out,
  output logic       cnt_up_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Registered state
  state_t     r_state;
  logic [7:0] r_start_val;
  logic [7:0] r_end_val;
  logic [3:0] r_passes;
  logic [7:0] r_target;
  logic       r_dir;
  logic [3:0] r_pass_cnt;
  logic       r_err;

  // Next-state values
  state_t     w_state_next;
  logic [7:0] w_start_val_next;
  logic [7:0] w_end_val_next;
  logic [3:0] w_passes_next;
  logic [7:0] w_target_next;
  logic       w_dir_next;
  logic [3:0] w_pass_cnt_next;
  logic       w_err_next;

  // Helpers
  logic       w_req_valid;
  logic       w_q_out_of_range;
  logic [3:0] w_pass_cnt_inc;

  assign w_req_valid = (start_val_in >= LO) && (start_val_in <= HI) &&
                       (end_val_in   >= LO) && (end_val_in   <= HI) &&
                       (start_val_in != end_val_in) &&
                       (passes_in != 4'd0);

  // Leaving the legal window means the counter wrapped or was disturbed; the
  // sweep cannot be trusted any more.
  assign w_q_out_of_range = (cnt_q_in < LO) || (cnt_q_in > HI);

  assign w_pass_cnt_inc = r_pass_cnt + 4'd1;

`ifdef CTRL_TIMEOUT_EN
  // Watchdog: counts RUN cycles that neither hold nor hit the target.
  // TIMEOUT_SLACK is expected to stay small (well below 256).
  localparam logic [8:0] L_SLACK = 9'(TIMEOUT_SLACK);

  logic [8:0] r_wdog;
  logic [8:0] w_wdog_next;
  logic [7:0] w_span;
  logic [8:0] w_wdog_limit;
  logic       w_wdog_expired;

  assign w_span         = (r_start_val > r_end_val) ? (r_start_val - r_end_val)
                                                    : (r_end_val - r_start_val);
  assign w_wdog_limit   = {1'b0, w_span} + L_SLACK;
  // The counter has already spent the whole allowance; the current cycle
  // would be one too many.
  assign w_wdog_expired = (r_wdog >= w_wdog_limit);
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_state     <= ST_IDLE;
      r_start_val <= 8'd0;
      r_end_val   <= 8'd0;
      r_passes    <= 4'd0;
      r_target    <= 8'd0;
      r_dir       <= 1'b1;
      r_pass_cnt  <= 4'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_start_val <= w_start_val_next;
      r_end_val   <= w_end_val_next;
      r_passes    <= w_passes_next;
      r_target    <= w_target_next;
      r_dir       <= w_dir_next;
      r_pass_cnt  <= w_pass_cnt_next;
      r_err       <= w_err_next;
    end
  end

`ifdef CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_wdog <= 9'd0;
    end else begin
      r_wdog <= w_wdog_next;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state and counter-control logic.
  // The counter controls are combinational from registered state and
  // cnt_q_in. A reversal therefore takes effect on the very edge at which
  // the endpoint is seen, so the counter does not dwell there.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_start_val_next = r_start_val;
    w_end_val_next   = r_end_val;
    w_passes_next    = r_passes;
    w_target_next    = r_target;
    w_dir_next       = r_dir;
    w_pass_cnt_next  = r_pass_cnt;
    w_err_next       = r_err;
`ifdef CTRL_TIMEOUT_EN
    w_wdog_next      = r_wdog;
`endif

    // Freeze unless a branch below explicitly lets the counter run.
    cnt_load_en_out  = 1'b1;
    cnt_d_out        = cnt_q_in;
    cnt_up_out       = r_dir;

    unique case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          if (w_req_valid) begin
            w_start_val_next = start_val_in;
            w_end_val_next   = end_val_in;
            w_passes_next    = passes_in;
            w_pass_cnt_next  = 4'd0;
            w_err_next       = 1'b0;
            w_state_next     = ST_LOAD;
          end else begin
            // A rejected request leaves the previous pass count visible.
            w_err_next   = 1'b1;
            w_state_next = ST_FINISH;
          end
        end
      end

      ST_LOAD: begin
        cnt_load_en_out = 1'b1;
        cnt_d_out       = r_start_val;
        w_target_next   = r_end_val;
        w_dir_next      = (r_end_val > r_start_val);
        cnt_up_out      = w_dir_next;
`ifdef CTRL_TIMEOUT_EN
        w_wdog_next     = 9'd0;
`endif
        w_state_next    = ST_RUN;
      end

      ST_RUN: begin
        if (abort_in) begin
          w_err_next   = 1'b1;
          w_state_next = ST_FINISH;
        end
`ifdef CTRL_TIMEOUT_EN
        else if (w_wdog_expired) begin
          w_err_next   = 1'b1;
          w_state_next = ST_FINISH;
        end
`endif
        else if (w_q_out_of_range) begin
          w_err_next   = 1'b1;
          w_state_next = ST_FINISH;
        end else if (hold_in) begin
          // The target compare waits for the release, so a hold that lands
          // on the endpoint still completes the pass afterwards.
          w_state_next = ST_RUN;
        end else if (cnt_q_in == r_target) begin
          w_pass_cnt_next = w_pass_cnt_inc;
`ifdef CTRL_TIMEOUT_EN
          w_wdog_next     = 9'd0;
`endif
          if (w_pass_cnt_inc == r_passes) begin
            w_state_next = ST_FINISH;
          end else begin
            w_target_next   = (r_target == r_end_val) ? r_start_val : r_end_val;
            w_dir_next      = ~r_dir;
            cnt_load_en_out = 1'b0;
            cnt_up_out      = ~r_dir;
          end
        end else begin
          cnt_load_en_out = 1'b0;
          cnt_up_out      = r_dir;
`ifdef CTRL_TIMEOUT_EN
          w_wdog_next     = r_wdog + 9'd1;
`endif
        end
      end

      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  assign busy_out     = (r_state != ST_IDLE);
  assign done_out     = (r_state == ST_FINISH);
  assign err_out      = (r_state == ST_FINISH) && r_err;
  assign pass_cnt_out = r_pass_cnt;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for counter_sweep_ctrl. A simple 8-bit up/down counter model is
// the controlled datapath. It can be overridden with a stuck value to inject
// faults. Expected counter trajectories come from the sweep rules: walk from
// the start value to each endpoint in turn, one step per cycle, and repeat
// the current value while hold is applied.
// ---------------------------------------------------------------------------
module tb_counter_sweep_ctrl;

  localparam logic [7:0] LO = 8'd10;
  localparam logic [7:0] HI = 8'd40;

  logic       clk = 1'b0;
  logic       reset_al_in = 1'b0;
  logic       start_in = 1'b0;
  logic [7:0] start_val_in = 8'd0;
  logic [7:0] end_val_in = 8'd0;
  logic [3:0] passes_in = 4'd0;
  logic       hold_in = 1'b0;
  logic       abort_in = 1'b0;
  logic       busy_out;
  logic       done_out;
  logic       err_out;
  logic [3:0] pass_cnt_out;
  logic [7:0] cnt_q_in;
  logic       cnt_load_en_out;
  logic [7:0] cnt_d_out;
  logic       cnt_up_out;

  // Counter model plus fault override
  logic [7:0] cnt_reg = 8'd0;
  logic       stuck_en = 1'b0;
  logic [7:0] stuck_val = 8'd0;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] last_passes = 4'd0;

  assign cnt_q_in = stuck_en ? stuck_val : cnt_reg;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_load_en_out)  cnt_reg <= cnt_d_out;
    else if (cnt_up_out)  cnt_reg <= cnt_reg + 8'd1;
    else                  cnt_reg <= cnt_reg - 8'd1;
  end

  counter_sweep_ctrl #(.LO(LO), .HI(HI)) dut (
    .clk             (clk),
    .reset_al_in     (reset_al_in),
    .start_in        (start_in),
    .start_val_in    (start_val_in),
    .end_val_in      (end_val_in),
    .passes_in       (passes_in),
    .hold_in         (hold_in),
    .abort_in        (abort_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .err_out         (err_out),
    .pass_cnt_out    (pass_cnt_out),
    .cnt_q_in        (cnt_q_in),
    .cnt_load_en_out (cnt_load_en_out),
    .cnt_d_out       (cnt_d_out),
    .cnt_up_out      (cnt_up_out)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "global timeout");
  end

  // -------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || err_out !== 1'b0 ||
        pass_cnt_out !== 4'd0 || cnt_up_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b pass=%0d up=%0b required 0 0 0 0 1",
               busy_out, done_out, err_out, pass_cnt_out, cnt_up_out);
    end
    checks++;
    if (cnt_load_en_out !== 1'b1 || cnt_d_out !== cnt_q_in) begin
      failures++;
      $display("FAIL reset_freeze: load_en=%0b d=%0d q=%0d required load_en=1 d=q",
               cnt_load_en_out, cnt_d_out, cnt_q_in);
    end
    reset_al_in = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset: done");
  endtask

  // One complete sweep, checked cycle by cycle against the expected walk.
  // hold_idx < 0 means no hold. With noise set, start_in and the request
  // fields are toggled while the sweep runs; the block must ignore them.
  task automatic do_sweep(input logic [7:0] s, input logic [7:0] e,
                          input logic [3:0] p, input int hold_idx,
                          input int hold_len, input bit noise);
    logic [7:0] exp_q[$];
    logic [7:0] v;
    logic [7:0] tgt;
    logic [7:0] fin;
    int         span;
    int         idx;
    int         holds_left;
    int         cyc;
    int         ec;
    span = (s > e) ? int'(s - e) : int'(e - s);
    v = s;
    exp_q.push_back(v);
    for (int k = 1; k <= int'(p); k++) begin
      tgt = (k % 2 == 1) ? e : s;
      while (v != tgt) begin
        v = (tgt > v) ? v + 8'd1 : v - 8'd1;
        exp_q.push_back(v);
      end
    end
    fin = exp_q[exp_q.size() - 1];

    @(negedge clk);
    start_val_in = s; end_val_in = e; passes_in = p;
    start_in = 1'b1; hold_in = 1'b0; abort_in = 1'b0;
    #1;
    checks++;
    if (busy_out !== 1'b0) begin
      failures++;
      $display("FAIL sweep_idle_busy: busy=%0b required 0", busy_out);
    end

    @(negedge clk);
    start_in = 1'b0;
    #1;
    checks++;
    if (busy_out !== 1'b1 || cnt_load_en_out !== 1'b1 || cnt_d_out !== s) begin
      failures++;
      $display("FAIL sweep_load: busy=%0b load_en=%0b d=%0d required 1 1 %0d",
               busy_out, cnt_load_en_out, cnt_d_out, s);
    end

    idx = 0;
    holds_left = hold_len;
    cyc = 0;
    while (idx < exp_q.size() && cyc < 600) begin
      @(negedge clk);
      cyc++;
      hold_in = (idx == hold_idx && holds_left > 0);
      if (noise) begin
        start_in     = 1'($urandom_range(0, 1));
        start_val_in = 8'($urandom_range(0, 60));
        end_val_in   = 8'($urandom_range(0, 60));
        passes_in    = 4'($urandom_range(0, 15));
      end
      #1;
      ec = (idx == 0) ? 0 : (idx - 1) / span;
      checks++;
      if (cnt_q_in !== exp_q[idx]) begin
        failures++;
        $display("FAIL sweep_cnt: step=%0d cnt=%0d required %0d", idx, cnt_q_in, exp_q[idx]);
      end
      checks++;
      if (pass_cnt_out !== 4'(ec) || busy_out !== 1'b1 || done_out !== 1'b0) begin
        failures++;
        $display("FAIL sweep_status: step=%0d pass=%0d busy=%0b done=%0b required %0d 1 0",
                 idx, pass_cnt_out, busy_out, done_out, ec);
      end
      if (hold_in) begin
        holds_left--;
        checks++;
        if (cnt_load_en_out !== 1'b1 || cnt_d_out !== cnt_q_in) begin
          failures++;
          $display("FAIL sweep_hold_freeze: load_en=%0b d=%0d q=%0d required load_en=1 d=q",
                   cnt_load_en_out, cnt_d_out, cnt_q_in);
        end
      end else begin
        checks++;
        if (idx == exp_q.size() - 1) begin
          if (cnt_load_en_out !== 1'b1 || cnt_d_out !== cnt_q_in) begin
            failures++;
            $display("FAIL sweep_final_freeze: load_en=%0b d=%0d required 1 %0d",
                     cnt_load_en_out, cnt_d_out, cnt_q_in);
          end
        end else if (cnt_load_en_out !== 1'b0 ||
                     cnt_up_out !== (exp_q[idx + 1] > exp_q[idx])) begin
          failures++;
          $display("FAIL sweep_dir: step=%0d load_en=%0b up=%0b required 0 %0b",
                   idx, cnt_load_en_out, cnt_up_out, exp_q[idx + 1] > exp_q[idx]);
        end
        idx++;
      end
    end
    if (idx < exp_q.size()) begin
      checks++;
      failures++;
      $display("FAIL sweep_budget: only %0d of %0d steps observed", idx, exp_q.size());
    end

    @(negedge clk);
    hold_in = 1'b0; start_in = 1'b0;
    #1;
    checks++;
    if (done_out !== 1'b1 || err_out !== 1'b0 || pass_cnt_out !== p ||
        cnt_q_in !== fin || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL sweep_done: done=%0b err=%0b pass=%0d cnt=%0d busy=%0b required 1 0 %0d %0d 1",
               done_out, err_out, pass_cnt_out, cnt_q_in, busy_out, p, fin);
    end
    last_passes = p;

    @(negedge clk);
    #1;
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || cnt_q_in !== fin || pass_cnt_out !== p) begin
      failures++;
      $display("FAIL sweep_idle_after: busy=%0b done=%0b cnt=%0d pass=%0d required 0 0 %0d %0d",
               busy_out, done_out, cnt_q_in, pass_cnt_out, fin, p);
    end
    $display("sweep start=%0d end=%0d passes=%0d hold_idx=%0d hold_len=%0d steps=%0d",
             s, e, p, hold_idx, hold_len, exp_q.size());
  endtask

  task automatic test_basic_up();
    do_sweep(8'd12, 8'd15, 4'd2, -1, 0, 1'b0);
  endtask

  task automatic test_full_down();
    do_sweep(8'd40, 8'd10, 4'd1, -1, 0, 1'b0);
  endtask

  task automatic test_hold();
    do_sweep(8'd20, 8'd25, 4'd1, 2, 3, 1'b0);   // hold at cnt=22
    do_sweep(8'd20, 8'd25, 4'd1, 5, 3, 1'b0);   // hold on the target value 25
  endtask

  task automatic do_invalid(input logic [7:0] s, input logic [7:0] e, input logic [3:0] p);
    logic [7:0] q0;
    @(negedge clk);
    q0 = cnt_q_in;
    start_val_in = s; end_val_in = e; passes_in = p; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    #1;
    checks++;
    if (done_out !== 1'b1 || err_out !== 1'b1 || busy_out !== 1'b1 ||
        cnt_load_en_out !== 1'b1 || cnt_d_out !== q0 || cnt_q_in !== q0 ||
        pass_cnt_out !== last_passes) begin
      failures++;
      $display("FAIL invalid_finish: done=%0b err=%0b busy=%0b load_en=%0b d=%0d q=%0d pass=%0d required 1 1 1 1 %0d %0d %0d",
               done_out, err_out, busy_out, cnt_load_en_out, cnt_d_out, cnt_q_in,
               pass_cnt_out, q0, q0, last_passes);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || cnt_q_in !== q0) begin
      failures++;
      $display("FAIL invalid_idle: busy=%0b done=%0b cnt=%0d required 0 0 %0d",
               busy_out, done_out, cnt_q_in, q0);
    end
    $display("invalid start=%0d end=%0d passes=%0d", s, e, p);
  endtask

  task automatic test_invalid();
    do_invalid(8'd9, 8'd20, 4'd1);
    do_invalid(8'd30, 8'd30, 4'd1);
    do_invalid(8'd12, 8'd20, 4'd0);
    do_invalid(8'd12, 8'd41, 4'd2);
  endtask

  // Start a sweep and step until the counter reads 'val' (bounded).
  task automatic start_and_reach(input logic [7:0] s, input logic [7:0] e,
                                 input logic [3:0] p, input logic [7:0] val,
                                 output bit found);
    found = 1'b0;
    @(negedge clk);
    start_val_in = s; end_val_in = e; passes_in = p; start_in = 1'b1;
    @(negedge clk);   // LOAD
    start_in = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk);
      if (cnt_q_in == val) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL reach_value: counter never reached %0d", val);
    end
  endtask

  task automatic test_abort();
    bit found;
    start_and_reach(8'd30, 8'd38, 4'd1, 8'd33, found);
    abort_in = 1'b1;
    #1;
    checks++;
    if (cnt_load_en_out !== 1'b1 || cnt_d_out !== 8'd33) begin
      failures++;
      $display("FAIL abort_freeze: load_en=%0b d=%0d required 1 33", cnt_load_en_out, cnt_d_out);
    end
    @(negedge clk);
    abort_in = 1'b0;
    #1;
    checks++;
    if (done_out !== 1'b1 || err_out !== 1'b1 || cnt_q_in !== 8'd33 || pass_cnt_out !== 4'd0) begin
      failures++;
      $display("FAIL abort_finish: done=%0b err=%0b cnt=%0d pass=%0d required 1 1 33 0",
               done_out, err_out, cnt_q_in, pass_cnt_out);
    end
    last_passes = 4'd0;
    @(negedge clk);
    #1;
    checks++;
    if (busy_out !== 1'b0 || cnt_q_in !== 8'd33) begin
      failures++;
      $display("FAIL abort_idle: busy=%0b cnt=%0d required 0 33", busy_out, cnt_q_in);
    end
    $display("abort at cnt=33 found=%0b", found);
  endtask

  task automatic test_range();
    bit found;
    start_and_reach(8'd20, 8'd30, 4'd2, 8'd23, found);
    stuck_val = 8'd45;
    stuck_en  = 1'b1;
    #1;
    checks++;
    if (cnt_load_en_out !== 1'b1 || cnt_d_out !== 8'd45) begin
      failures++;
      $display("FAIL range_freeze: load_en=%0b d=%0d required 1 45", cnt_load_en_out, cnt_d_out);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_out !== 1'b1 || err_out !== 1'b1) begin
      failures++;
      $display("FAIL range_finish: done=%0b err=%0b required 1 1", done_out, err_out);
    end
    last_passes = 4'd0;
    @(negedge clk);
    stuck_en = 1'b0;
    $display("range violation at cnt=23 -> 45 found=%0b", found);
  endtask

  task automatic test_reset_mid_run();
    bit found;
    bit saw_done;
    start_and_reach(8'd12, 8'd40, 4'd3, 8'd17, found);
    reset_al_in = 1'b0;
    #1;
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || err_out !== 1'b0 ||
        pass_cnt_out !== 4'd0 || cnt_up_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_run: busy=%0b done=%0b err=%0b pass=%0d up=%0b required 0 0 0 0 1",
               busy_out, done_out, err_out, pass_cnt_out, cnt_up_out);
    end
    @(negedge clk);
    reset_al_in = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (done_out !== 1'b0 || busy_out !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_no_done: done or busy seen after reset, required none");
    end
    last_passes = 4'd0;
    $display("reset mid-run found=%0b", found);
  endtask

  task automatic test_stuck_counter();
    int done_at;
    stuck_val = 8'd14;
    stuck_en  = 1'b1;
    @(negedge clk);
    start_val_in = 8'd12; end_val_in = 8'd16; passes_in = 4'd1; start_in = 1'b1;
    @(negedge clk);   // LOAD
    start_in = 1'b0;
`ifdef CTRL_TIMEOUT_EN
    done_at = 0;
    for (int c = 1; c <= 14 && done_at == 0; c++) begin
      @(negedge clk);
      #1;
      if (done_out === 1'b1) begin
        done_at = c;
        checks++;
        if (err_out !== 1'b1) begin
          failures++;
          $display("FAIL timeout_err: err=%0b required 1", err_out);
        end
      end
    end
    checks++;
    if (done_at < 9 || done_at > 11) begin
      failures++;
      $display("FAIL timeout_latency: done after %0d cycles, required 9..11", done_at);
    end
`else
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      #1;
      if (busy_out !== 1'b1 || done_out !== 1'b0) done_at = c;
    end
    checks++;
    if (done_at != 0) begin
      failures++;
      $display("FAIL stuck_busy: sweep ended at cycle %0d, required busy for 40 cycles", done_at);
    end
    @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    #1;
    checks++;
    if (done_out !== 1'b1 || err_out !== 1'b1) begin
      failures++;
      $display("FAIL stuck_abort: done=%0b err=%0b required 1 1", done_out, err_out);
    end
`endif
    last_passes = 4'd0;
    @(negedge clk);
    stuck_en = 1'b0;
    @(negedge clk);
    $display("stuck counter at 14 result_cycle=%0d", done_at);
  endtask

  task automatic test_random();
    logic [7:0] s;
    logic [7:0] e;
    logic [3:0] p;
    int         hi;
    int         hl;
    int         span;
    for (int n = 0; n < 25; n++) begin
      s = 8'($urandom_range(int'(LO), int'(HI)));
      do e = 8'($urandom_range(int'(LO), int'(HI))); while (e == s);
      p = 4'($urandom_range(1, 4));
      span = (s > e) ? int'(s - e) : int'(e - s);
      if ($urandom_range(0, 1) == 1) begin
        hi = $urandom_range(0, span * int'(p));
        hl = $urandom_range(1, 4);
      end else begin
        hi = -1;
        hl = 0;
      end
      do_sweep(s, e, p, hi, hl, 1'b1);
      if ($urandom_range(0, 3) == 0)
        do_invalid(8'($urandom_range(0, 9)), e, p);
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_full_down();
    test_hold();
    test_invalid();
    test_abort();
    test_range();
    test_reset_mid_run();
    test_stuck_counter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the bounded 8-bit up/down counter (load/d/direction datapath, range LO..HI, default 10..40).
- Accepts a sweep request (start value, end value, pass count), loads the counter, and ping-pongs it between the two endpoints for N passes.
- Holds the counter frozen when idle or paused, then reports completion or error.
- Sits between a software/FSM requester and the counter instance.

Parameters:
- LO, 10, lowest legal counter value.
- HI, 40, highest legal counter value.
- TIMEOUT_SLACK, 4, extra non-hold cycles allowed per pass before watchdog abort (used only with CTRL_TIMEOUT_EN).

Ports:
- clk  input  1  rising-edge clock.
- reset_al_in  input  1  asynchronous active-low reset.
- start_in  input  1  sweep request, sampled in IDLE only.
- start_val_in  input  8  first endpoint.
- end_val_in  input  8  second endpoint.
- passes_in  input  4  number of passes (one pass = one endpoint-to-endpoint traverse).
- hold_in  input  1  pause sweep, counter frozen.
- abort_in  input  1  terminate sweep with error.
- busy_out  output  1  high in any state except IDLE.
- done_out  output  1  one-cycle completion pulse.
- err_out  output  1  one-cycle error pulse, coincident with done_out.
- pass_cnt_out  output  4  passes completed in the current/last sweep.
- cnt_q_in  input  8  counter current value.
- cnt_load_en_out  output  1  counter synchronous load enable.
- cnt_d_out  output  8  counter load data.
- cnt_up_out  output  1  counter direction, 1 = up.

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE; pass_cnt, done, err and latched parameters clear.
  - busy_out=0, done_out=0, err_out=0, pass_cnt_out=0, cnt_up_out=1.
- Counter-control outputs are combinational from registered state and cnt_q_in. This lets a reversal take effect on the same edge at which target is seen.
- Freeze:
  - Means cnt_load_en_out=1, cnt_d_out=cnt_q_in.
  - Applied in IDLE, FINISH, during hold, and whenever not explicitly running.
- IDLE:
  - Freeze.
  - On start_in, parameters are valid when both endpoints are in [LO,HI], start_val_in != end_val_in, and passes_in != 0.
  - Valid: latch parameters, clear pass_cnt, go to LOAD.
  - Invalid: go to FINISH with err flagged.
- LOAD (1 cycle):
  - cnt_load_en_out=1, cnt_d_out=start_val.
  - Set target=end_val, dir=(end_val>start_val).
  - Go to RUN.
- RUN:
  - Priority order: abort_in > out-of-range cnt_q_in > hold_in > target reached > count.
  - abort_in: freeze; go to FINISH with err.
  - cnt_q_in outside [LO,HI]: freeze; go to FINISH with err. This guards against counter wrap corrupting the sweep.
  - hold_in: freeze; stay in RUN. Target compare is deferred, so a hold in the target cycle still completes the pass after release.
  - cnt_q_in==target:
    - pass_cnt increments.
    - If the new pass_cnt==passes: freeze; go to FINISH.
    - Otherwise swap target between start_val and end_val, invert dir, and drive cnt_load_en_out=0 with cnt_up_out=new dir. The counter leaves the endpoint on the same edge, with no dwell cycle.
  - Otherwise: cnt_load_en_out=0, cnt_up_out=dir.
- FINISH (1 cycle):
  - Freeze.
  - done_out=1; err_out=1 if err was flagged.
  - Go to IDLE.
  - pass_cnt_out holds its value until the next accepted start.
- start_in outside IDLE is ignored.
- hold_in and abort_in in IDLE/LOAD/FINISH are ignored.
- Pass length = |end_val-start_val| counting cycles. Sweep latency = 1 (LOAD) + passes*|end-start| + 1 (load edge) + hold cycles. done_out follows 1 cycle after the final target hit.
- All arithmetic is unsigned 8-bit. The counter never reaches its own wrap point under control, because reversal occurs at endpoints inside [LO,HI].

Optional Feature:
- Macro: CTRL_TIMEOUT_EN.
- Defined:
  - A per-pass watchdog counts RUN cycles without hold and clears at each target hit and in LOAD.
  - When it exceeds |end-start|+TIMEOUT_SLACK, the block freezes and goes to FINISH with err. Priority is just below abort_in.
- Undefined: no watchdog logic. Errors arise only from invalid parameters, range violation, or abort.

Test Plan:
- start 12, end 15, passes 2: counter loaded 12, then counts 13,14,15,14,13,12. done_out pulses 1 cycle after the second 12; err_out=0, pass_cnt_out=2, counter stays 12.
- start 40, end 10, passes 1: cnt_up_out=0 throughout; counter runs 40 down to 10 over 30 cycles. done_out follows with no wrap to 40.
- Hold: start 20, end 25, passes 1; hold_in high for 3 cycles at cnt=22, including when cnt=25 is reached on a second run. Counter stays at 22 for 3 cycles, and the pass completes after release. Total latency is +3.
- Invalid requests: start 9, or start==end==30, or passes=0. Each gives the FINISH pulse with done_out=1, err_out=1, no load issued, counter value unchanged.
- Abort mid-sweep at cnt=33 (start 30, end 38): counter frozen at 33, done_out=1 and err_out=1 on the next cycle. Asserting reset_al_in low mid-RUN instead returns busy_out=0 immediately, with no done pulse.
- With CTRL_TIMEOUT_EN: force cnt_q_in stuck at 14 (start 12, end 16). err_out fires after 4+4 running cycles; without the macro, busy_out stays high indefinitely.
